mem_addr_sel_reg: RTL and testbench
===================================

Name: mem_addr_sel_reg

Overview:
- Parametrised, registered successor to the combinational memory-address source select in the multicycle datapath.
- Selects one of N_SRC address sources (PC, ALUOut, exception vectors, etc.) on a request and latches it.
- Holds the latched address stable on the memory address bus for a programmable number of wait cycles, then signals completion to the control unit.
- Invalid selector codes are rejected with an error pulse rather than silently aliased.

Parameters:
- WIDTH, 32: width of each address source and of addr_out.
- N_SRC, 5: number of address sources; legal range 2..(2**SEL_W).
- SEL_W, 3: width of selector.
- MEM_LAT, 1: extra cycles the address is held after capture; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- selector  input  SEL_W  binary index of the source to capture; sampled only with req.
- data_in  input  N_SRC*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
- req  input  1  start capture/hold transaction; level-sampled each edge.
- addr_out  output  WIDTH  registered, latched address driven to memory.
- busy  output  1  high while a transaction holds the address.
- done  output  1  one-cycle completion pulse.
- sel_err  output  1  one-cycle pulse: req with selector >= N_SRC.

Behaviour:
- Reset (synchronous, active-high):
  - Affects only the next rising clk edge with reset=1.
  - At that edge: addr_out=0, busy=0, done=0, sel_err=0, state=IDLE, counter=0.
  - Reset overrides req and any in-flight transaction; a transaction killed by reset never produces done.
- State machine: two states, IDLE and HOLD. busy=1 exactly when state=HOLD. An internal counter is 8 bits wide.
- IDLE, req=1, selector<N_SRC at edge E0:
  - addr_out <= data_in[selector]; state <= HOLD; counter <= MEM_LAT.
  - busy reads 1 after E0.
- IDLE, req=1, selector>=N_SRC:
  - sel_err=1 for the following cycle only.
  - addr_out unchanged; state stays IDLE.
- IDLE, req=0: nothing changes; done and sel_err return to 0.
- HOLD, each edge:
  - If counter==0: state <= IDLE, done <= 1 for one cycle.
  - Otherwise: counter <= counter-1.
  - req, selector and data_in changes are ignored; addr_out is frozen.
- Latency:
  - Capture at E0; done high in the cycle after edge E0+MEM_LAT+1.
  - busy is high for exactly MEM_LAT+1 cycles.
  - MEM_LAT=0 gives busy for 1 cycle, done in the 2nd cycle after capture.
- Back-to-back: in the cycle where done=1 the block is in IDLE. A req sampled at the end of that cycle starts a new transaction immediately, so there are no dead cycles.
- addr_out keeps its last captured value in IDLE until the next valid capture or reset.
- done and sel_err are never high in the same cycle. A sel_err can directly follow a done.
- Selector comparison is unsigned and full-width. When N_SRC == 2**SEL_W, no code is invalid and sel_err is constant 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset release, then idle 3 cycles -> addr_out=0x00000000, busy=0, done=0, sel_err=0 throughout.
- MEM_LAT=2, sources k=0x1000_0000+k, req=1 with selector=3 for 1 cycle -> addr_out=0x10000003 from next cycle; busy=1 for 3 cycles; then done=1 for 1 cycle; busy=0.
- During the same HOLD, change selector to 1 and source 3 to 0xDEADBEEF, and pulse req -> addr_out stays 0x10000003; no second done.
- req with selector=6 (N_SRC=5) in IDLE -> sel_err=1 for exactly 1 cycle; addr_out unchanged; busy stays 0.
- MEM_LAT=0, req held high with selector=0 then 4 -> captures 0x10000000, done, then 0x10000004 captured in the done cycle's following edge; busy pattern 1,0(done),1,0(done).
- Assert reset in the 2nd HOLD cycle -> next edge gives addr_out=0, busy=0; done never asserted for the aborted transaction.

Source files
------------

// File: rtl/mem_addr_sel_reg.sv
// Registered memory-address source select: captures one of N_SRC sources on req,
// holds it for MEM_LAT+1 cycles, then pulses done. Illegal selectors pulse sel_err.
module mem_addr_sel_reg #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned N_SRC   = 5,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SEL_W-1:0]       selector,
  input  logic [N_SRC*WIDTH-1:0] data_in,
  input  logic                   req,
  output logic [WIDTH-1:0]       addr_out,
  output logic                   busy,
  output logic                   done,
  output logic                   sel_err
);

  localparam int unsigned CNT_W = 8;
  // Some selector codes are illegal only when N_SRC leaves part of the code space unused
  localparam bit HAS_BAD = (SEL_W < 32) && (N_SRC < (32'd1 << SEL_W));

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   src_c;
  logic               sel_bad_c;

  // Source mux; only legal codes select a source, illegal codes are rejected below
  always_comb begin
    src_c = '0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      if (selector == SEL_W'(k)) src_c = data_in[k*WIDTH +: WIDTH];
    end
  end

  assign sel_bad_c = HAS_BAD && (32'(selector) >= N_SRC);

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (sel_bad_c) begin
            err_d = 1'b1;
          end else begin
            addr_d  = src_c;
            cnt_d   = CNT_W'(MEM_LAT);
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Inputs are ignored while holding; the address stays frozen
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_out = addr_q;
  assign busy     = (state_q == HOLD);
  assign done     = done_q;
  assign sel_err  = err_q;

endmodule

// File: tb/tb_mem_addr_sel_reg.sv
// Scoreboard bench for mem_addr_sel_reg: one instance with MEM_LAT=2, one with MEM_LAT=0.
module tb_mem_addr_sel_reg;

  localparam int unsigned W  = 32;
  localparam int unsigned NS = 5;
  localparam int unsigned SW = 3;

  typedef struct {
    bit          is_err;
    logic [31:0] addr;
    int          cyc;
    int          blen;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  logic [SW-1:0]    sel_a = '0, sel_b = '0;
  logic [NS*W-1:0]  din_a, din_b;
  logic             req_a = 1'b0, req_b = 1'b0;
  logic [W-1:0]     addr_a, addr_b;
  logic             busy_a, busy_b, done_a, done_b, err_a, err_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   blen[2];
  int   nchk = 0;
  int   nerr = 0;

  mem_addr_sel_reg #(.WIDTH(W), .N_SRC(NS), .SEL_W(SW), .MEM_LAT(2)) u_a (
    .clk(clk), .reset(reset), .selector(sel_a), .data_in(din_a), .req(req_a),
    .addr_out(addr_a), .busy(busy_a), .done(done_a), .sel_err(err_a)
  );

  mem_addr_sel_reg #(.WIDTH(W), .N_SRC(NS), .SEL_W(SW), .MEM_LAT(0)) u_b (
    .clk(clk), .reset(reset), .selector(sel_b), .data_in(din_b), .req(req_b),
    .addr_out(addr_b), .busy(busy_b), .done(done_b), .sel_err(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops an expected event whenever a DUT presents done or sel_err
  task automatic mon(input int i, input logic dn, input logic er, input logic bs,
                     input logic [31:0] ad);
    exp_t e;
    if (dn && er) chk($sformatf("done_and_err_%0d", i), 64'(1), 64'(0));
    if (dn || er) begin
      if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
        chk($sformatf("unexpected_event_%0d", i), {62'd0, dn, er}, 64'(0));
      end else begin
        e = (i == 0) ? q_a.pop_front() : q_b.pop_front();
        chk($sformatf("event_kind_%0d", i), 64'(er), 64'(e.is_err));
        chk($sformatf("event_addr_%0d", i), 64'(ad), 64'(e.addr));
        chk($sformatf("event_cycle_%0d", i), 64'(cyc), 64'(e.cyc));
        if (e.is_err) chk($sformatf("err_busy_%0d", i), 64'(bs), 64'(0));
        else chk($sformatf("busy_len_%0d", i), 64'(blen[i]), 64'(e.blen));
      end
    end
    if (bs) blen[i]++;
    else blen[i] = 0;
  endtask

  always @(negedge clk) begin
    mon(0, done_a, err_a, busy_a, addr_a);
    mon(1, done_b, err_b, busy_b, addr_b);
  end

  initial begin
    exp_t e;
    int   k;
    blen[0] = 0;
    blen[1] = 0;
    for (int s = 0; s < int'(NS); s++) begin
      din_a[s*W +: W] = 32'h1000_0000 + 32'(s);
      din_b[s*W +: W] = 32'h1000_0000 + 32'(s);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Idle after reset: everything zero
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("idle_a", {addr_a, busy_a, done_a, err_a}, 64'(0));
      chk("idle_b", {addr_b, busy_b, done_b, err_b}, 64'(0));
    end

    // A: capture source 3, hold 3 cycles, ignore a req during HOLD
    @(negedge clk);
    k = cyc;
    req_a = 1'b1; sel_a = 3'd3;
    e = '{is_err: 1'b0, addr: 32'h1000_0003, cyc: k + 4, blen: 3};
    q_a.push_back(e);
    @(negedge clk);
    chk("cap_addr_a", 64'(addr_a), 64'h1000_0003);
    chk("cap_busy_a", 64'(busy_a), 64'(1));
    sel_a = 3'd1;
    din_a[3*W +: W] = 32'hDEAD_BEEF;
    @(negedge clk);
    req_a = 1'b0;
    chk("frozen_addr_a", 64'(addr_a), 64'h1000_0003);
    repeat (4) @(negedge clk);
    chk("after_done_busy_a", 64'(busy_a), 64'(0));

    // A: illegal selector 6
    k = cyc;
    req_a = 1'b1; sel_a = 3'd6;
    e = '{is_err: 1'b1, addr: 32'h1000_0003, cyc: k + 1, blen: 0};
    q_a.push_back(e);
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    chk("err_one_cycle_a", {busy_a, err_a}, 64'(0));
    chk("err_addr_kept_a", 64'(addr_a), 64'h1000_0003);

    // B (MEM_LAT=0): req held high, selector 0 then 4, then illegal 5 right after done
    @(negedge clk);
    k = cyc;
    req_b = 1'b1; sel_b = 3'd0;
    e = '{is_err: 1'b0, addr: 32'h1000_0000, cyc: k + 2, blen: 1};
    q_b.push_back(e);
    e = '{is_err: 1'b0, addr: 32'h1000_0004, cyc: k + 4, blen: 1};
    q_b.push_back(e);
    e = '{is_err: 1'b1, addr: 32'h1000_0004, cyc: k + 5, blen: 0};
    q_b.push_back(e);
    @(negedge clk);
    chk("b2b_busy1", 64'(busy_b), 64'(1));
    @(negedge clk);
    chk("b2b_busy0", 64'(busy_b), 64'(0));
    sel_b = 3'd4;
    @(negedge clk);
    chk("b2b_busy2", 64'(busy_b), 64'(1));
    req_b = 1'b0;
    @(negedge clk);
    req_b = 1'b1; sel_b = 3'd5;
    @(negedge clk);
    req_b = 1'b0;
    repeat (2) @(negedge clk);

    // A: reset in the 2nd HOLD cycle kills the transaction
    k = cyc;
    req_a = 1'b1; sel_a = 3'd2;
    @(negedge clk);
    req_a = 1'b0;
    chk("abort_cap_addr", 64'(addr_a), 64'h1000_0002);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_reset_addr", 64'(addr_a), 64'(0));
    chk("abort_reset_busy", 64'(busy_a), 64'(0));
    repeat (6) @(negedge clk);

    chk("queue_a_empty", 64'(q_a.size()), 64'(0));
    chk("queue_b_empty", 64'(q_b.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
